// File: rtl/cnn_pkg.sv
// Shared types for the CNN feature-map datapath.
// - DATA_WIDTH : width of one signed feature
// - feature_t  : signed feature word
// - up_state_t : FSM states of the 2x2 upsampler
// - cnt_w()    : counter width for a terminal count n (never below 1 bit)
package cnn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] feature_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TOP  = 2'd1,
        PREP = 2'd2,
        BOT  = 2'd3
    } up_state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsample_2x2_if.sv
// Stream bundle of the 2x2 upsampler.
// Ports (signal names are those of the block):
// - i_start                           frame start request
// - i_valid / i_ready / i_features    pooled feature input stream
// - o_valid / o_ready / o_features    upsampled feature output stream
// - o_eol / o_eoc / o_done            row end, channel end, frame done
// - dbg_state                         current FSM state, for observation
// Handshake: a beat transfers on a rising clock edge where valid & ready are
// both high; once valid is raised, it and its payload stay stable until that
// transfer happens, and ready may depend combinationally on state but never
// on the same-cycle valid of the other side.
// Modports: slave = the upsampler, master = whoever drives and consumes it.
interface upsample_2x2_if;
    import cnn_pkg::*;

    logic      i_start;
    logic      i_valid;
    logic      i_ready;
    feature_t  i_features;
    logic      o_valid;
    logic      o_ready;
    feature_t  o_features;
    logic      o_eol;
    logic      o_eoc;
    logic      o_done;
    up_state_t dbg_state;

    modport slave (
        input  i_start, i_valid, i_features, o_ready,
        output i_ready, o_valid, o_features, o_eol, o_eoc, o_done, dbg_state
    );

    modport master (
        output i_start, i_valid, i_features, o_ready,
        input  i_ready, o_valid, o_features, o_eol, o_eoc, o_done, dbg_state
    );
endinterface

// File: rtl/upsample_line_buf.sv
// One pooled row of features, written while the even output row is produced
// and replayed for the odd output row.
// Ports:
// - clk_i                  clock
// - wr_en_i/wr_addr_i/wr_data_i   write port
// - rd_en_i/rd_addr_i      read request; data appears on rd_data_o next cycle
// - rd_data_o              registered read data, held until the next read
module upsample_line_buf
    import cnn_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  feature_t      wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output feature_t      rd_data_o
);
    feature_t mem_q [DEPTH];
    feature_t rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/upsample_2x2.sv
// Nearest-neighbour 2x2 unpool. Each pooled feature becomes a 2x2 block:
// on the even output row every input is emitted twice and stored in the line
// buffer; on the odd output row the stored row is replayed, again twice each.
// Ports:
// - i_clk  clock
// - i_rst  synchronous active-high reset; aborts any frame in progress
// - bus    stream bundle (slave side), see upsample_2x2_if
module upsample_2x2
    import cnn_pkg::*;
#(
    parameter int NUM_CHANNELS = 6,
    parameter int NUM_IN_COLS  = 14,
    parameter int NUM_IN_ROWS  = 14
) (
    input  logic           i_clk,
    input  logic           i_rst,
    upsample_2x2_if.slave  bus
);
    localparam int COL_W = cnt_w(NUM_IN_COLS);
    localparam int ROW_W = cnt_w(NUM_IN_ROWS);
    localparam int CH_W  = cnt_w(NUM_CHANNELS);

    up_state_t        state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    feature_t         hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             hold_last_q, hold_last_d;   // held value is the last column
    logic             dup_q, dup_d;               // held value is on its second beat
    logic             rd_avail_q, rd_avail_d;     // line-buffer read data is pending use
    logic             done_q, done_d;

    logic             wr_en, rd_en, load;
    logic [COL_W-1:0] rd_addr;
    feature_t         rd_data, load_data;
    logic             col_last, row_last, ch_last;
    logic             can_load, row_locked, in_ready, fire, row_done, eol;

    upsample_line_buf #(.DEPTH(NUM_IN_COLS), .AW(COL_W)) u_line_buf (
        .clk_i     (i_clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (col_q),
        .wr_data_i (bus.i_features),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign col_last = (col_q == COL_W'(NUM_IN_COLS - 1));
    assign row_last = (row_q == ROW_W'(NUM_IN_ROWS - 1));
    assign ch_last  = (ch_q == CH_W'(NUM_CHANNELS - 1));

    // The hold register can take a new value when empty, or when its second
    // beat is leaving this cycle.
    assign can_load   = ~hold_valid_q | (dup_q & bus.o_ready);
    // Once the last column of a row is held, the next input belongs to the
    // next row and must wait until the odd row has been replayed.
    assign row_locked = hold_valid_q & hold_last_q;
    assign in_ready   = (state_q == TOP) & can_load & ~row_locked;
    assign fire       = hold_valid_q & bus.o_ready;
    assign row_done   = fire & dup_q & hold_last_q;
    assign eol        = hold_valid_q & dup_q & hold_last_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        ch_d         = ch_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
        dup_d        = dup_q;
        rd_avail_d   = rd_avail_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = col_q + COL_W'(1);
        load         = 1'b0;
        load_data    = hold_q;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the old frame.
                if (bus.i_start && !done_q) begin
                    state_d = TOP;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                end
            end
            TOP: begin
                if (in_ready && bus.i_valid) begin
                    load      = 1'b1;
                    load_data = bus.i_features;
                    wr_en     = 1'b1;
                end
                if (row_done) state_d = PREP;
            end
            PREP: begin
                // Fetch column 0 so it is ready on the first BOT cycle.
                rd_en      = 1'b1;
                rd_addr    = '0;
                rd_avail_d = 1'b1;
                state_d    = BOT;
            end
            BOT: begin
                if (rd_avail_q && can_load) begin
                    load      = 1'b1;
                    load_data = rd_data;
                    // Prefetch the next column while this one is emitted.
                    rd_en      = ~col_last;
                    rd_avail_d = ~col_last;
                end
                if (row_done) begin
                    if (row_last) begin
                        row_d = '0;
                        if (ch_last) begin
                            ch_d    = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            ch_d    = ch_q + CH_W'(1);
                            state_d = TOP;
                        end
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = TOP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire) begin
            if (!dup_q) begin
                dup_d = 1'b1;
            end else begin
                dup_d        = 1'b0;
                hold_valid_d = 1'b0;
            end
        end
        if (load) begin
            hold_d       = load_data;
            hold_valid_d = 1'b1;
            dup_d        = 1'b0;
            hold_last_d  = col_last;
            col_d        = col_last ? '0 : col_q + COL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            dup_q        <= 1'b0;
            rd_avail_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            dup_q        <= dup_d;
            rd_avail_q   <= rd_avail_d;
            done_q       <= done_d;
        end
    end

    assign bus.i_ready    = in_ready;
    assign bus.o_valid    = hold_valid_q;
    assign bus.o_features = hold_q;
    assign bus.o_eol      = eol;
    assign bus.o_eoc      = eol & (state_q == BOT) & row_last;
    assign bus.o_done     = done_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_upsample_2x2.sv
module tb_upsample_2x2;
    import cnn_pkg::*;

    localparam int EW   = DATA_WIDTH + 2;   // {eoc, eol, feature}
    localparam int L_CH = 6;
    localparam int L_R  = 14;
    localparam int L_C  = 14;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    upsample_2x2_if sif ();
    upsample_2x2_if lif ();

    upsample_2x2 #(.NUM_CHANNELS(1), .NUM_IN_COLS(2), .NUM_IN_ROWS(2)) dut_s (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (sif)
    );

    upsample_2x2 #(.NUM_CHANNELS(L_CH), .NUM_IN_COLS(L_C), .NUM_IN_ROWS(L_R)) dut_l (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (lif)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_s_q[$];
    logic [EW-1:0] exp_l_q[$];
    bit            done_exp[2];
    int            done_cnt[2];
    int            beats[2];
    int            eol_cnt[2];
    int            eoc_cnt[2];
    bit            stall_pend[2];
    logic [EW-1:0] stall_val[2];
    bit            rdy_rand_s = 1'b0;
    bit            rdy_rand_l = 1'b0;
    int            in_acc_l = 0;
    feature_t      src_s[];
    feature_t      src_l[];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_stats(input int d);
        done_cnt[d] = 0;
        beats[d]    = 0;
        eol_cnt[d]  = 0;
        eoc_cnt[d]  = 0;
    endtask

    // Reference: every output pixel (r, c) is input pixel (r/2, c/2).
    task automatic model_frame(input int d, input int nch, input int nr, input int nc,
                               input feature_t src[]);
        logic [EW-1:0] e;
        bit eol, eoc;
        for (int ch = 0; ch < nch; ch++)
            for (int orow = 0; orow < 2 * nr; orow++)
                for (int ocol = 0; ocol < 2 * nc; ocol++) begin
                    eol = (ocol == 2 * nc - 1);
                    eoc = eol && (orow == 2 * nr - 1);
                    e = {eoc, eol, src[(ch * nr + orow / 2) * nc + ocol / 2]};
                    if (d == 0) exp_s_q.push_back(e);
                    else        exp_l_q.push_back(e);
                end
    endtask

    // ---------------- output compare ----------------
    task automatic check_out(input int d, input logic v, input logic r, input feature_t f,
                             input logic eol, input logic eoc, input logic done);
        logic [EW-1:0] got, e;
        bit empty;
        got = {eoc, eol, f};
        if (done_exp[d]) begin
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL done_after_last[%0d]: got %b expected 1", d, done);
            end
            done_exp[d] = 1'b0;
        end else if (done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected[%0d]: got 1 expected 0", d);
        end
        if (done === 1'b1) done_cnt[d]++;
        if (stall_pend[d]) begin
            checks++;
            if (v !== 1'b1 || got !== stall_val[d]) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b %h expected v=1 %h", d, v, got, stall_val[d]);
            end
        end
        stall_pend[d] = (v === 1'b1) && (r !== 1'b1);
        stall_val[d]  = got;
        if (v === 1'b1 && r === 1'b1) begin
            beats[d]++;
            if (eol) eol_cnt[d]++;
            if (eoc) eoc_cnt[d]++;
            empty = (d == 0) ? (exp_s_q.size() == 0) : (exp_l_q.size() == 0);
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL extra_beat[%0d]: got %h expected no beat", d, got);
            end else begin
                e = (d == 0) ? exp_s_q.pop_front() : exp_l_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL beat[%0d] #%0d: got %h expected %h", d, beats[d], got, e);
                end
                if ((d == 0) ? (exp_s_q.size() == 0) : (exp_l_q.size() == 0)) done_exp[d] = 1'b1;
            end
        end
    endtask

    always @(negedge i_clk) begin
        check_out(0, sif.o_valid, sif.o_ready, sif.o_features, sif.o_eol, sif.o_eoc, sif.o_done);
        check_out(1, lif.o_valid, lif.o_ready, lif.o_features, lif.o_eol, lif.o_eoc, lif.o_done);
    end

    always @(posedge i_clk) begin
        #1;
        sif.o_ready = rdy_rand_s ? 1'($urandom_range(0, 1)) : 1'b1;
        lif.o_ready = rdy_rand_l ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- drivers ----------------
    task automatic push_in_s(input feature_t v, input bit gaps, input bit noise);
        int budget = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            if (noise) sif.i_start = 1'($urandom_range(0, 1));
            step();
        end
        sif.i_valid    = 1'b1;
        sif.i_features = v;
        forever begin
            if (noise) sif.i_start = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            if (sif.i_ready) begin
                step();
                break;
            end
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL in_timeout_s: got no i_ready expected accept within 200 cycles");
                step();
                break;
            end
            step();
        end
        sif.i_valid = 1'b0;
    endtask

    task automatic push_in_l(input feature_t v, input bit gaps);
        int budget = 0;
        if (gaps) repeat ($urandom_range(0, 1)) step();
        lif.i_valid    = 1'b1;
        lif.i_features = v;
        forever begin
            @(negedge i_clk);
            if (lif.i_ready) begin
                in_acc_l++;
                step();
                break;
            end
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL in_timeout_l: got no i_ready expected accept within 200 cycles");
                step();
                break;
            end
            step();
        end
        lif.i_valid = 1'b0;
    endtask

    task automatic set_src4(input int a, input int b, input int c, input int e);
        src_s = new[4];
        src_s[0] = feature_t'(a);
        src_s[1] = feature_t'(b);
        src_s[2] = feature_t'(c);
        src_s[3] = feature_t'(e);
    endtask

    task automatic run_frame_s(input string tag, input bit rnd, input bit noise);
        int budget = 0;
        bit got_done = 1'b0;
        clear_stats(0);
        model_frame(0, 1, 2, 2, src_s);
        rdy_rand_s = rnd;
        sif.i_start = 1'b1;
        step();
        sif.i_start = 1'b0;
        for (int k = 0; k < 4; k++) push_in_s(src_s[k], rnd, noise);
        while (!got_done && budget < 200) begin
            if (noise) sif.i_start = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            got_done = sif.o_done;
            budget++;
            step();
        end
        sif.i_start = 1'b0;
        rdy_rand_s  = 1'b0;
        repeat (3) step();
        check({tag, "_done_seen"}, int'(got_done), 1);
        check({tag, "_idle_after"}, int'(sif.dbg_state), int'(IDLE));
        check({tag, "_queue_left"}, exp_s_q.size(), 0);
        check({tag, "_beats"}, beats[0], 16);
        check({tag, "_eol"}, eol_cnt[0], 4);
        check({tag, "_eoc"}, eoc_cnt[0], 1);
        check({tag, "_done_cnt"}, done_cnt[0], 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int budget;
        bit got_done;
        sif.i_start = 1'b0; sif.i_valid = 1'b0; sif.i_features = '0;
        lif.i_start = 1'b0; lif.i_valid = 1'b0; lif.i_features = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;

        @(negedge i_clk);
        check("rst_o_valid", int'(sif.o_valid), 0);
        check("rst_i_ready", int'(sif.i_ready), 0);
        check("rst_o_eol", int'(sif.o_eol), 0);
        check("rst_o_eoc", int'(sif.o_eoc), 0);
        check("rst_o_done", int'(sif.o_done), 0);
        check("rst_o_features", int'(sif.o_features), 0);
        check("rst_state", int'(sif.dbg_state), int'(IDLE));
        check("rst_state_l", int'(lif.dbg_state), int'(IDLE));
        step();

        // Model pins for input 1,2,3,4: beat 4 is {eol,2}, beat 9 is 3, beat 16 is {eoc,eol,4}.
        set_src4(1, 2, 3, 4);
        model_frame(0, 1, 2, 2, src_s);
        check("model_beat1", int'(exp_s_q[0]), 32'h00001);
        check("model_beat4", int'(exp_s_q[3]), 32'h10002);
        check("model_beat9", int'(exp_s_q[8]), 32'h00003);
        check("model_beat16", int'(exp_s_q[15]), 32'h30004);
        exp_s_q.delete();

        run_frame_s("basic", 1'b0, 1'b0);

        set_src4(-5, 32767, -32768, 0);
        run_frame_s("signs", 1'b0, 1'b0);

        set_src4(1, 2, 3, 4);
        run_frame_s("stall", 1'b1, 1'b0);

        set_src4(int'($urandom_range(0, 65535)), -1, 7, int'($urandom_range(0, 65535)));
        run_frame_s("start_noise", 1'b1, 1'b1);

        // Abort in the middle of the odd row.
        set_src4(1, 2, 3, 4);
        clear_stats(0);
        model_frame(0, 1, 2, 2, src_s);
        sif.i_start = 1'b1;
        step();
        sif.i_start = 1'b0;
        push_in_s(src_s[0], 1'b0, 1'b0);
        push_in_s(src_s[1], 1'b0, 1'b0);
        budget = 0;
        forever begin
            @(negedge i_clk);
            if (sif.dbg_state == BOT || budget > 50) break;
            budget++;
            step();
        end
        check("abort_reached_bot", int'(sif.dbg_state), int'(BOT));
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        exp_s_q.delete();
        stall_pend[0] = 1'b0;
        done_exp[0]   = 1'b0;
        @(negedge i_clk);
        check("abort_o_valid", int'(sif.o_valid), 0);
        check("abort_i_ready", int'(sif.i_ready), 0);
        check("abort_state", int'(sif.dbg_state), int'(IDLE));
        step();
        repeat (4) step();
        check("abort_no_done", done_cnt[0], 0);
        run_frame_s("after_abort", 1'b0, 1'b0);

        // Full default-size frame with random data, gaps and backpressure.
        src_l = new[L_CH * L_R * L_C];
        foreach (src_l[k]) src_l[k] = feature_t'($urandom());
        clear_stats(1);
        model_frame(1, L_CH, L_R, L_C, src_l);
        check("model_l_size", exp_l_q.size(), 4704);
        rdy_rand_l = 1'b1;
        in_acc_l   = 0;
        lif.i_start = 1'b1;
        step();
        lif.i_start = 1'b0;
        foreach (src_l[k]) push_in_l(src_l[k], 1'b1);
        budget   = 0;
        got_done = 1'b0;
        while (!got_done && budget < 2000) begin
            @(negedge i_clk);
            got_done = lif.o_done;
            budget++;
            step();
        end
        rdy_rand_l = 1'b0;
        repeat (3) step();
        check("full_done_seen", int'(got_done), 1);
        check("full_beats", beats[1], 4704);
        check("full_inputs", in_acc_l, 1176);
        check("full_eol", eol_cnt[1], 168);
        check("full_eoc", eoc_cnt[1], 6);
        check("full_done_cnt", done_cnt[1], 1);
        check("full_queue_left", exp_l_q.size(), 0);
        check("full_idle_after", int'(lif.dbg_state), int'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
